pipe_hazard_ctl: RTL and testbench

Central stall/flush controller for the in-order pipeline (fe, id, ex, me, wb and any deeper variants). It replaces hand-driven per-stage clr/stall with generated vectors. It runs a per-register scoreboard of in-flight writes for RAW interlock, merges per-stage busy requests, and applies branch redirects. It sits beside the stage chain; the id stage supplies operand/destination indices and wb reports retirement.

---
 rtl/pipe_hazard_ctl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// Central stall/flush controller: RAW scoreboard, busy merging and branch redirect
// for an in-order pipeline, producing per-stage hold and bubble vectors.
module pipe_hazard_ctl #(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned REG_IDX_W      = 5,
  parameter int unsigned REDIRECT_STAGE = 2,
  parameter int unsigned WB_BYPASS      = 1,
  parameter int unsigned CNT_W          = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_id_valid,
  input  logic [REG_IDX_W-1:0]  i_id_rs1,
  input  logic                  i_id_rs1_en,
  input  logic [REG_IDX_W-1:0]  i_id_rs2,
  input  logic                  i_id_rs2_en,
  input  logic                  i_id_dest_en,
  input  logic [REG_IDX_W-1:0]  i_id_dest_reg,
  input  logic                  i_wb_dest_en,
  input  logic [REG_IDX_W-1:0]  i_wb_dest_reg,
  input  logic [NUM_STAGES-1:0] i_stage_busy,
  input  logic                  i_redirect,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic [NUM_STAGES-1:0] o_clr,
  output logic                  o_issue,
  output logic [31:0]           o_hazard_cycles,
  output logic                  o_sb_err
);

  localparam int unsigned NUM_REGS = 1 << REG_IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]      cnt     [NUM_REGS];
  logic [CNT_W-1:0]      cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0]      cnt_rs1, cnt_rs2;
  logic                  pend_rs1, pend_rs2, raw;
  logic                  redir_eff, inc_en, dec_en, err_set, hazard_cnt_en;
  logic [NUM_STAGES-1:0] busy, stall_v, clr_v;

  assign cnt_rs1 = cnt[i_id_rs1];
  assign cnt_rs2 = cnt[i_id_rs2];

  // A single outstanding write retiring this cycle is visible through the write-through file
  assign pend_rs1 = (cnt_rs1 != '0) &&
                    !((WB_BYPASS != 0) && (cnt_rs1 == CNT_ONE) && i_wb_dest_en &&
                      (i_wb_dest_reg == i_id_rs1));
  assign pend_rs2 = (cnt_rs2 != '0) &&
                    !((WB_BYPASS != 0) && (cnt_rs2 == CNT_ONE) && i_wb_dest_en &&
                      (i_wb_dest_reg == i_id_rs2));

  assign raw = i_id_valid &&
               ((i_id_rs1_en && (i_id_rs1 != '0) && pend_rs1) ||
                (i_id_rs2_en && (i_id_rs2 != '0) && pend_rs2));

  // Stall/bubble/redirect network
  always_comb begin
    busy      = i_stage_busy | (NUM_STAGES'(raw) << 1);
    stall_v   = '0;
    clr_v     = '0;
    stall_v[NUM_STAGES-1] = busy[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      stall_v[k] = stall_v[k+1] | busy[k];
    end
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      clr_v[k+1] = stall_v[k] & ~stall_v[k+1];
    end
    redir_eff = i_redirect & ~stall_v[REDIRECT_STAGE];
    if (redir_eff) begin
      for (int k = 0; k < REDIRECT_STAGE; k++) begin
        stall_v[k] = 1'b0;
        clr_v[k]   = 1'b1;
      end
    end
    o_issue = i_id_valid & ~stall_v[1] & ~clr_v[1] & ~redir_eff;
    o_stall = stall_v;
    o_clr   = clr_v;
    if (clr) begin
      o_stall = '0;
      o_clr   = '1;
      o_issue = 1'b0;
    end
  end

  assign inc_en        = o_issue && i_id_dest_en && (i_id_dest_reg != '0);
  assign dec_en        = i_wb_dest_en && (i_wb_dest_reg != '0);
  assign hazard_cnt_en = raw && (i_stage_busy[NUM_STAGES-1:2] == '0);

  // Scoreboard next state; coincident inc/dec on one entry cancel
  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (inc_en && (i_id_dest_reg == REG_IDX_W'(i)) &&
          !(dec_en && (i_wb_dest_reg == REG_IDX_W'(i)))) begin
        if (cnt[i] == CNT_MAX) err_set = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec_en && (i_wb_dest_reg == REG_IDX_W'(i)) &&
                   !(inc_en && (i_id_dest_reg == REG_IDX_W'(i)))) begin
        if (cnt[i] == '0) err_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      o_hazard_cycles <= '0;
      o_sb_err        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
      if (hazard_cnt_en) o_hazard_cycles <= o_hazard_cycles + 32'd1;
      if (err_set)       o_sb_err        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed vector bench for pipe_hazard_ctl: a cycle-by-cycle table with hand-computed
// expectations, plus a scoreboard saturation sequence.
module tb_pipe_hazard_ctl;

  logic        clk = 1'b0;
  logic        clr;
  logic        i_id_valid, i_id_rs1_en, i_id_rs2_en, i_id_dest_en, i_wb_dest_en, i_redirect;
  logic [4:0]  i_id_rs1, i_id_rs2, i_id_dest_reg, i_wb_dest_reg, i_stage_busy;
  logic [4:0]  o_stall, o_clr;
  logic        o_issue, o_sb_err;
  logic [31:0] o_hazard_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctl dut (
    .clk(clk), .clr(clr),
    .i_id_valid(i_id_valid),
    .i_id_rs1(i_id_rs1), .i_id_rs1_en(i_id_rs1_en),
    .i_id_rs2(i_id_rs2), .i_id_rs2_en(i_id_rs2_en),
    .i_id_dest_en(i_id_dest_en), .i_id_dest_reg(i_id_dest_reg),
    .i_wb_dest_en(i_wb_dest_en), .i_wb_dest_reg(i_wb_dest_reg),
    .i_stage_busy(i_stage_busy), .i_redirect(i_redirect),
    .o_stall(o_stall), .o_clr(o_clr), .o_issue(o_issue),
    .o_hazard_cycles(o_hazard_cycles), .o_sb_err(o_sb_err)
  );

  typedef struct {
    logic        clr, valid;
    logic [4:0]  rs1;
    logic        rs1_en;
    logic [4:0]  rs2;
    logic        rs2_en, dest_en;
    logic [4:0]  dest;
    logic        wb_en;
    logic [4:0]  wb, busy;
    logic        redirect;
    logic [4:0]  e_stall, e_clr;
    logic        e_issue;
    logic [31:0] e_hz;
    logic        e_err, chk_reg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int c, int v, int r1, int r1e, int r2, int r2e, int de, int d,
                              int we, int w, int b, int rd, int es, int ec, int ei,
                              int ehz, int eerr, int chk);
    vec_t t;
    t.clr = 1'(c);    t.valid = 1'(v);
    t.rs1 = 5'(r1);   t.rs1_en = 1'(r1e);
    t.rs2 = 5'(r2);   t.rs2_en = 1'(r2e);
    t.dest_en = 1'(de); t.dest = 5'(d);
    t.wb_en = 1'(we); t.wb = 5'(w);
    t.busy = 5'(b);   t.redirect = 1'(rd);
    t.e_stall = 5'(es); t.e_clr = 5'(ec); t.e_issue = 1'(ei);
    t.e_hz = 32'(ehz); t.e_err = 1'(eerr); t.chk_reg = 1'(chk);
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check just after
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    clr = t.clr; i_id_valid = t.valid;
    i_id_rs1 = t.rs1; i_id_rs1_en = t.rs1_en;
    i_id_rs2 = t.rs2; i_id_rs2_en = t.rs2_en;
    i_id_dest_en = t.dest_en; i_id_dest_reg = t.dest;
    i_wb_dest_en = t.wb_en; i_wb_dest_reg = t.wb;
    i_stage_busy = t.busy; i_redirect = t.redirect;
    #1;
    check({tag, " stall"}, 32'(o_stall), 32'(t.e_stall));
    check({tag, " clr"},   32'(o_clr),   32'(t.e_clr));
    check({tag, " issue"}, 32'(o_issue), 32'(t.e_issue));
    if (t.chk_reg) begin
      check({tag, " hazard_cycles"}, o_hazard_cycles, t.e_hz);
      check({tag, " sb_err"}, 32'(o_sb_err), 32'(t.e_err));
    end
  endtask

  initial begin
    clr = 1'b1; i_id_valid = 1'b0; i_id_rs1 = '0; i_id_rs1_en = 1'b0;
    i_id_rs2 = '0; i_id_rs2_en = 1'b0; i_id_dest_en = 1'b0; i_id_dest_reg = '0;
    i_wb_dest_en = 1'b0; i_wb_dest_reg = '0; i_stage_busy = '0; i_redirect = 1'b0;

    //                 clr v  rs1 e rs2 e de d  we w  busy     rd stall    clr      is hz er chk
    // reset held 4 cycles, id offering a write that must not be recorded
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 1));
    // back-to-back RAW on x1, released by the wb-retire cycle
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 5'b00000, 0, 5'b00011, 5'b00100, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 5'b00000, 0, 5'b00011, 5'b00100, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2, 1, 1, 5'b00000, 0, 5'b00000, 5'b00000, 1, 2, 0, 1));
    // x0 is never tracked; independent registers do not interlock
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 2, 0, 1));
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 2, 0, 1));
    // busy propagation
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 0, 5'b01111, 5'b10000, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 0, 5'b11111, 5'b00000, 0, 2, 0, 1));
    // redirect: immediate flush, then deferred while stage 3 busy, then taken
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 5'b00000, 1, 5'b00000, 5'b00011, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 1, 5'b01111, 5'b10000, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 5'b00000, 5'b00011, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 2, 0, 1));
    // RAW through rs2 on x3, then retire x3 and x2
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 5'b00000, 0, 5'b00011, 5'b00100, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 1, 3, 5'b00000, 0, 5'b00000, 5'b00000, 1, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3, 0, 1));
    // simultaneous inc/dec on x5 leaves cnt[5]=1, proven by the following RAW stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 1, 5, 5'b00000, 0, 5'b00000, 5'b00000, 1, 3, 0, 1));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00011, 5'b00100, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0, 1));
    // RAW while stage 2 busy is not counted as a hazard cycle
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 4, 0, 1));
    tbl.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 5'b00100, 0, 5'b00111, 5'b01000, 0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0, 1));
    // fe busy alone: bubble into id, nothing issues
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 5'b00001, 0, 5'b00001, 5'b00010, 0, 4, 0, 1));
    // underflow on x7 sets sticky error, cleared only by clr
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b11111, 0, 4, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Saturation: seven writes to x10 fill the 3-bit entry, the eighth overflows
    for (int i = 0; i < 8; i++)
      apply(mk(0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0, 0, 1),
            $sformatf("sat%0d", i));
    apply(mk(0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00011, 5'b00100, 0, 0, 1, 1), "sat_raw");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 1, 1), "sat_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
